// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Default geometry and timing.
    localparam int DMEM_DEPTH  = 64;
    localparam int DMEM_RD_LAT = 2;

    // Width of the read-latency down-counter (enough for RD_LAT up to 7).
    localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed read latency.
// A request is accepted on an edge where req_valid && req_ready; stores commit
// on that same edge and loads capture the word as it stands then. The response
// is a registered one-cycle pulse produced from the RESP state.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int RD_LAT = DMEM_RD_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // BUSY dwells RD_LAT-1 cycles: counter starts at RD_LAT-2 and exits at 0.
    localparam logic [CNT_W-1:0] LOAD_CNT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ready;
    logic             r_err;
    logic [31:0]      r_hold;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [31:0]      r_rsp_rdata;

    logic [29:0]      w_word;
    logic             w_err;
    logic             w_accept;
    logic             w_wr;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_rdata;

    // Address decode: word index, misalignment / range check.
    assign w_word   = req_addr[31:2];
    assign w_err    = (req_addr[1:0] != 2'b00) || (w_word >= 30'(DEPTH));
    assign w_idx    = req_addr[AW+1:2];
    assign w_accept = req_valid && r_ready;
    assign w_wr     = w_accept && req_we && !w_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_wr),
        .i_be    (req_be),
        .i_addr  (w_idx),
        .i_wdata (req_wdata),
        .o_rdata (w_rdata)
    );

    // Next-state and latency-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_we || w_err || (RD_LAT == 1)) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = LOAD_CNT;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == '0) w_state_nxt = RESP;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counter and ready registers; ready mirrors "next state is IDLE".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == IDLE);
        end
    end

    // Capture the request result at acceptance; errors and stores return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_hold <= (!req_we && !w_err) ? w_rdata : 32'h0;
            r_err  <= w_err;
        end
    end

    // Registered response pulse, zeroed outside the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= (r_state == RESP);
            r_rsp_err   <= (r_state == RESP) && r_err;
            r_rsp_rdata <= (r_state == RESP) ? r_hold : 32'h0;
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RD_LAT=2 main instance, RD_LAT=1 second.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: RD_LAT=2
    logic        a_valid, a_ready, a_we, a_rv, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    // Instance B: RD_LAT=1
    logic        b_valid, b_ready, b_we, b_rv, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    dmem_responder #(.DEPTH(64), .RD_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    dmem_responder #(.DEPTH(64), .RD_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? b_ready : a_ready;
    endfunction

    function automatic logic vld(input bit s);
        return s ? b_rv : a_rv;
    endfunction

    function automatic logic [31:0] rdat(input bit s);
        return s ? b_rdata : a_rdata;
    endfunction

    function automatic logic rer(input bit s);
        return s ? b_err : a_err;
    endfunction

    task automatic drive(input bit s, input logic v, input logic we,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be);
        if (s) begin
            b_valid = v; b_we = we; b_addr = ad; b_wdata = wd; b_be = be;
        end else begin
            a_valid = v; a_we = we; a_addr = ad; a_wdata = wd; a_be = be;
        end
    endtask

    // Issue one request, measure edges from accept to rsp_valid, capture response.
    task automatic do_req(input bit s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int lat, output logic [31:0] rd, output logic er);
        int w;
        lat = -1; rd = 32'h0; er = 1'b0; w = 0;
        @(negedge clk);
        while (!rdy(s) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!rdy(s)) begin
            chk("ready_timeout", 32'(rdy(s)), 32'h1);
            return;
        end
        drive(s, 1'b1, we, addr, wdata, be);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("ready_low_after_accept", 32'(rdy(s)), 32'h0);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (vld(s)) begin
                lat = e;
                rd  = rdat(s);
                er  = rer(s);
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            chk("pulse_then_zero", {vld(s), rer(s), rdat(s) != 32'h0}, 32'h0);
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          acc, nrdy, seen;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        //                we    addr       wdata         be     lat rdata         err
        vt[0]  = '{1'b1, 32'h20,  32'hDEADBEEF, 4'hF, 1, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h20,  32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h04,  32'h11223344, 4'hF, 1, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 32'h04,  32'hAABBCCDD, 4'h5, 1, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h04,  32'h0,        4'h0, 2, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1'b0, 32'h22,  32'h0,        4'h0, 1, 32'h0,        1'b1};
        vt[6]  = '{1'b0, 32'h100, 32'h0,        4'h0, 1, 32'h0,        1'b1};
        vt[7]  = '{1'b1, 32'h100, 32'h55555555, 4'hF, 1, 32'h0,        1'b1};
        vt[8]  = '{1'b1, 32'h06,  32'hFFFFFFFF, 4'hF, 1, 32'h0,        1'b1};
        vt[9]  = '{1'b0, 32'h04,  32'h0,        4'h0, 2, 32'h11BB33DD, 1'b0};
        vt[10] = '{1'b0, 32'h20,  32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
        vt[11] = '{1'b1, 32'h20,  32'h0,        4'h0, 1, 32'h0,        1'b0};
        vt[12] = '{1'b0, 32'h20,  32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
        vt[13] = '{1'b1, 32'hFC,  32'hCAFEF00D, 4'hF, 1, 32'h0,        1'b0};
        vt[14] = '{1'b0, 32'hFC,  32'h0,        4'h0, 2, 32'hCAFEF00D, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", 32'(a_ready), 32'h0);
        chk("rst_outs_a", {a_rv, a_err, a_rdata != 32'h0}, 32'h0);
        chk("rst_ready_b", 32'(b_ready), 32'h0);
        chk("rst_outs_b", {b_rv, b_err, b_rdata != 32'h0}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst_a", 32'(a_ready), 32'h1);
        chk("ready_after_rst_b", 32'(b_ready), 32'h1);

        // Table-driven transactions on the RD_LAT=2 instance
        for (int i = 0; i < 15; i++) begin
            do_req(1'b0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, lat, rd, er);
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_rdata", i), rd,       vt[i].rdata);
            chk($sformatf("v%0d_err", i),   32'(er),  32'(vt[i].err));
        end

        // req_valid held high for 12 cycles with alternating load addresses
        @(negedge clk);
        seen = 0;
        while (!a_ready && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        acc = 0; nrdy = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 32'h04 : 32'h20, 32'h0, 4'h0);
            if (a_ready) acc++;
            else         nrdy++;
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("stream_accepts", 32'(acc), 32'd4);
        chk("stream_not_ready", 32'(nrdy), 32'd8);
        repeat (5) @(negedge clk);

        // Reset pulsed while a load is in BUSY
        while (!a_ready) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        rst = 1'b1;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (a_rv || a_ready) seen++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midop_rst", 32'(a_ready), 32'h1);
        repeat (4) begin
            @(posedge clk);
            #1;
            if (a_rv) seen++;
        end
        chk("no_rsp_after_abandon", 32'(seen), 32'h0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        chk("post_rst_load_lat", 32'(lat), 32'd2);
        chk("post_rst_load_data", rd, 32'hDEADBEEF);

        // RD_LAT=1 instance
        do_req(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, lat, rd, er);
        chk("lat1_store_lat", 32'(lat), 32'd1);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        chk("lat1_load_lat", 32'(lat), 32'd1);
        chk("lat1_load_data", rd, 32'hDEADBEEF);
        chk("lat1_load_err", 32'(er), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
